// File: rtl/sm83_idu_pkg.sv
// Shared types for the sequential SM83 IDU: operation codes, FSM states and
// the carry-in rule that distinguishes a real increment/decrement from a pass.
package sm83_idu_pkg;

    typedef enum logic [1:0] {
        IDU_PASS = 2'b00,
        IDU_INC  = 2'b01,
        IDU_DEC  = 2'b10,
        IDU_RSVD = 2'b11
    } idu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } idu_state_t;

    // Inc/dec inject a 1 into slice 0; pass and the reserved code inject nothing.
    function automatic logic op_cin(idu_op_t op);
        return (op == IDU_INC) || (op == IDU_DEC);
    endfunction

endpackage

// File: rtl/sm83_idu_slice.sv
// One SLICE-bit increment/decrement step with carry/borrow out.
module sm83_idu_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] slice,
    input  logic             dec,
    input  logic             cin,
    output logic [SLICE-1:0] result,
    output logic             cout
);

    always_comb begin
        result = dec ? (slice - SLICE'(cin)) : (slice + SLICE'(cin));
        // Ripple only when the slice saturates in the direction of travel.
        cout   = cin & (dec ? (slice == '0) : (&slice));
    end

endmodule

// File: rtl/sm83_idu_seq.sv
// Sequential IDU: inc/dec/pass on a WIDTH-bit operand, one SLICE-bit slice per clock.
// Build option: define SM83_IDU_SEQ_EARLY_EXIT_EN to stop as soon as the carry dies out.
module sm83_idu_seq
    import sm83_idu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_operand,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_wrap,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

`ifdef SM83_IDU_SEQ_EARLY_EXIT_EN
    localparam logic EARLY_EXIT = 1'b1;
`else
    localparam logic EARLY_EXIT = 1'b0;
`endif

    if ((SLICE < 1) || (WIDTH < SLICE) || ((WIDTH % SLICE) != 0)) begin : g_bad_cfg
        $fatal(1, "sm83_idu_seq: WIDTH must be a non-zero multiple of SLICE");
    end

    idu_state_t       state, state_nx;
    idu_op_t          op_q;
    logic [WIDTH-1:0] res;
    logic [KW-1:0]    k;
    logic             carry;
    logic             wrap;
    logic [SLICE-1:0] cur_slice;
    logic [SLICE-1:0] new_slice;
    logic             cout;
    logic             last;
    logic             finish;

    assign cur_slice = res[k*SLICE +: SLICE];

    sm83_idu_slice #(.SLICE(SLICE)) u_slice (
        .slice  (cur_slice),
        .dec    (op_q == IDU_DEC),
        .cin    (carry),
        .result (new_slice),
        .cout   (cout)
    );

    assign last   = (k == KLAST);
    assign finish = last | (EARLY_EXIT & ~cout);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = CALC;
            CALC:    if (finish)    state_nx = DONE;
            DONE:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand register doubles as the result register; slices are rewritten in place.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            res   <= '0;
            op_q  <= IDU_PASS;
            k     <= '0;
            carry <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        res   <= req_operand;
                        op_q  <= idu_op_t'(req_op);
                        k     <= '0;
                        carry <= op_cin(idu_op_t'(req_op));
                        wrap  <= 1'b0;
                    end
                end
                CALC: begin
                    res[k*SLICE +: SLICE] <= new_slice;
                    carry                 <= cout;
                    wrap                  <= last ? cout : 1'b0;
                    if (!finish) k <= k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign rsp_valid  = (state == DONE);
    assign busy       = (state == CALC) || (state == DONE);
    assign rsp_result = res;
    assign rsp_wrap   = wrap;

endmodule

// File: doc/sm83_idu_seq.md
Name: sm83_idu_seq

Overview:
- Parametrised, sequential successor to the IDU control decode: performs increment, decrement or pass-through on a WIDTH-bit operand.
- Carry/borrow ripples one SLICE-bit slice per clock through a small FSM.
- Valid/ready handshakes on request and response sides.
- Sits between the register-file/address-bus control logic and the address latch; sized for address-width operands.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SLICE (elaboration-time $fatal otherwise)
SLICE, 4, bits processed per CALC cycle; NSLICE = WIDTH/SLICE, must be >= 1

Ports:
clk  input  1  clock, all state on rising edge
nreset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_op  input  2  00 pass, 01 inc, 10 dec, 11 reserved (treated as pass)
req_operand  input  WIDTH  value to modify
rsp_valid  output  1  result available (high only in DONE)
rsp_ready  input  1  consumer takes result
rsp_result  output  WIDTH  operand +1 / -1 / unchanged, modulo 2^WIDTH
rsp_wrap  output  1  carry out of MSB on inc (all-ones input), borrow out on dec (zero input); 0 for pass
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE, req_ready=1, rsp_valid=0, rsp_result=0, rsp_wrap=0, busy=0, slice index=0, internal carry=0.
- States: IDLE, CALC, DONE.
- IDLE: req_ready=1. On an edge with req_valid=1, capture operand into the result register, op, and slice index k=0. Carry-in is 1 for inc/dec and 0 for pass/reserved. Go to CALC.
- CALC: each edge processes slice k, replacing bits [k*SLICE +: SLICE] with slice +/- carry-in, and latches carry-out.
  - Inc carry-out = slice was all-ones and carry-in=1.
  - Dec borrow-out = slice was zero and carry-in=1.
  - Go to DONE when k = NSLICE-1, or on early exit (optional feature below); otherwise k <= k+1.
  - rsp_wrap <= carry-out of the final processed slice only when k = NSLICE-1; otherwise 0.
- DONE: rsp_valid=1; rsp_result and rsp_wrap stable. On an edge with rsp_ready=1, go to IDLE. No combinational path from req_valid/rsp_ready to any output.
- Latency: request accepted on edge E. The processed-slice count is C (C=NSLICE without early exit). rsp_valid is high in the cycle after edge E+C. Throughput is one op per C+2 cycles; no overlap.
- Pass/reserved: carry-in 0, so an early-exit build finishes after 1 CALC cycle and a fixed build after NSLICE cycles; result equals operand.
- Boundaries:
  - Inc of all-ones gives 0 with wrap=1.
  - Dec of 0 gives all-ones with wrap=1.
  - NSLICE=1 gives a single CALC cycle.
  - req_valid while busy is ignored; the requester must hold it, and it is accepted once back in IDLE.
  - req_op/req_operand are only sampled on the accept edge.
- Reset mid-CALC or mid-DONE: immediate return to IDLE with all outputs at reset values; the in-flight op is discarded with no response.

Optional Feature:
SM83_IDU_SEQ_EARLY_EXIT_EN
- Defined: in CALC, if the latched carry-out is 0 after processing slice k, go to DONE immediately. Upper slices are already correct and wrap=0. C = index of the first slice producing no carry, +1.
- Undefined: always NSLICE CALC cycles regardless of data, giving fixed latency. Results and wrap are identical in both builds; only timing differs.

Decomposition:
- Package sm83_idu_pkg:
  - idu_op_t enum: IDU_PASS=2'b00, IDU_INC=2'b01, IDU_DEC=2'b10, IDU_RSVD=2'b11.
  - idu_state_t enum: IDLE, CALC, DONE.
  - A function deriving carry-in from idu_op_t.
- Sub-module sm83_idu_slice #(SLICE): combinational; inputs slice, dec, cin; outputs result and cout. Instantiated once and muxed by k.

Test Plan (WIDTH=16, SLICE=4):
- inc 16'h1230, rsp_ready=1 -> result 16'h1231, wrap 0; C=1 with EARLY_EXIT, 4 without.
- inc 16'h00FF -> 16'h0100, wrap 0; C=3 with EARLY_EXIT. inc 16'hFFFF -> 16'h0000, wrap 1, C=4.
- dec 16'h0000 -> 16'hFFFF, wrap 1, C=4. dec 16'h0100 -> 16'h00FF, wrap 0, C=3 with EARLY_EXIT.
- op 11 and op 00 on 16'hBEEF -> 16'hBEEF, wrap 0.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid/result stable, req_ready=0, a second req_valid is not accepted until after the rsp_ready handshake.
- Drop nreset during CALC of dec 16'h8000 -> IDLE immediately, rsp_valid never asserts, outputs at reset values; next request completes normally.
